// File: rtl/seg7_score_scan.sv
// Three-digit 7-segment scanner for BCD score digits: strobed shadow latch,
// leading-zero blanking, dash for non-BCD digits and whole-display blink.
module seg7_score_scan #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_HALF = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic       upd,
  input  logic       lz_en,
  input  logic       blink_en,
  output logic [7:0] seg,
  output logic [2:0] an
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    sel_q, sel_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          started_q, started_d;
  logic [3:0]    sh_one_q, sh_one_d, sh_ten_q, sh_ten_d, sh_hun_q, sh_hun_d;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic       tick;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] dec;

  always_comb begin
    tick   = (div_q == DW'(SCAN_DIV - 1));
    div_d  = tick ? '0 : div_q + DW'(1);

    case (sel_q)
      2'd0:    sel_d = tick ? 2'd1 : 2'd0;
      2'd1:    sel_d = tick ? 2'd2 : 2'd1;
      2'd2:    sel_d = tick ? 2'd0 : 2'd2;
      default: sel_d = 2'd0;
    endcase

    sh_one_d = upd ? one : sh_one_q;
    sh_ten_d = upd ? ten : sh_ten_q;
    sh_hun_d = upd ? hun : sh_hun_q;

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    // Outputs stay dark for the first edge after reset so an=001 appears on the second.
    started_d = 1'b1;

    digit = 4'd0;
    blank = 1'b0;
    case (sel_q)
      2'd0: digit = sh_one_q;
      2'd1: begin
        digit = sh_ten_q;
        blank = lz_en && (sh_hun_q == 4'd0) && (sh_ten_q == 4'd0);
      end
      2'd2: begin
        digit = sh_hun_q;
        blank = lz_en && (sh_hun_q == 4'd0);
      end
      default: blank = 1'b1;
    endcase

    case (digit)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase

    an_d  = 3'b000;
    seg_d = 8'h00;
    if (started_q && !(blink_en && phase_q) && (sel_q != 2'd3)) begin
      an_d  = 3'b001 << sel_q;
      seg_d = blank ? 8'h00 : {1'b0, dec};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sel_q     <= 2'd0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      started_q <= 1'b0;
      sh_one_q  <= 4'd0;
      sh_ten_q  <= 4'd0;
      sh_hun_q  <= 4'd0;
      seg_q     <= 8'h00;
      an_q      <= 3'b000;
    end else begin
      div_q     <= div_d;
      sel_q     <= sel_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      started_q <= started_d;
      sh_one_q  <= sh_one_d;
      sh_ten_q  <= sh_ten_d;
      sh_hun_q  <= sh_hun_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
